// File: rtl/imem_loader_pkg.sv
// Shared constants for the boot-time instruction-memory loader: state codes,
// reset PC and frame layout.
package imem_loader_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LEN_HI = 3'd1;
   localparam state_t ST_LEN_LO = 3'd2;
   localparam state_t ST_DATA   = 3'd3;
   localparam state_t ST_CSUM   = 3'd4;
   localparam state_t ST_RUN    = 3'd5;
   localparam state_t ST_ERR    = 3'd6;

   // Must track the core's PC reset value so the first fetch hits word 0.
   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   function automatic logic is_receiving(input state_t st);
      return (st == ST_LEN_HI) || (st == ST_LEN_LO) || (st == ST_DATA) || (st == ST_CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the loader.
interface imem_loader_if;

   logic        load_start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_wdata;
   logic        cpu_run;
   logic        busy;
   logic        error;

   modport master (
      output load_start, in_valid, in_data,
      input  in_ready, im_we, im_addr, im_wdata, cpu_run, busy, error
   );

   modport slave (
      input  load_start, in_valid, in_data,
      output in_ready, im_we, im_addr, im_wdata, cpu_run, busy, error
   );

endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Packs big-endian bytes into 32-bit words; word_valid pulses the cycle after
// the fourth byte of a word is accepted, and word holds until the next one.
module imem_loader_byte_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        last_byte,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam int CNT_W   = $clog2(BYTES_PER_WORD);
   localparam int SHIFT_W = (BYTES_PER_WORD - 1) * 8;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic [31:0]        word_q, word_d;
   logic               word_valid_q, word_valid_d;
   logic [31:0]        assembled;

   // Earlier bytes move up one lane; the incoming byte lands in the LSB lane.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
         assign assembled[8*(gi+1) +: 8] = shift_q[8*gi +: 8];
      end
   endgenerate
   assign assembled[7:0] = byte_data;

   assign last_byte = byte_valid && !clr && (cnt_q == LAST_CNT);

   always_comb begin
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      if (clr) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (byte_valid) begin
         if (cnt_q == LAST_CNT) begin
            word_d       = assembled;
            word_valid_d = 1'b1;
            cnt_d        = '0;
            shift_d      = '0;
         end else begin
            shift_d = assembled[SHIFT_W-1:0];
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         shift_q      <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign word_valid = word_valid_q;
   assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length/data/XOR-checksum frame, writes it into
// instruction memory from BASE_ADDR, and releases the core once it verifies.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = RESET_PC,
   parameter int          DEPTH_WORDS = 256
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus
);

   localparam int LEN_W = LEN_BYTES * 8;
   localparam logic [LEN_W:0] MAX_LEN = DEPTH_WORDS[LEN_W:0];

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] word_idx_q, word_idx_d;
   logic [7:0]       csum_q, csum_d;
   logic [31:0]      im_addr_q, im_addr_d;

   logic             in_ready;
   logic             accept;
   logic             restart;
   logic             pk_byte_valid;
   logic             pk_last_byte;
   logic             pk_word_valid;
   logic [31:0]      pk_word;
   logic [LEN_W-1:0] len_full;

   assign in_ready      = is_receiving(state_q);
   assign accept        = bus.in_valid && in_ready;
   assign restart       = bus.load_start &&
                          ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_ERR));
   assign pk_byte_valid = accept && (state_q == ST_DATA);
   assign len_full      = {len_q[LEN_W-9:0], bus.in_data};

   imem_loader_byte_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (restart),
      .byte_valid (pk_byte_valid),
      .byte_data  (bus.in_data),
      .last_byte  (pk_last_byte),
      .word_valid (pk_word_valid),
      .word       (pk_word)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      csum_d     = csum_q;
      im_addr_d  = im_addr_q;
      if (restart) begin
         state_d    = ST_LEN_HI;
         len_d      = '0;
         word_idx_d = '0;
         csum_d     = '0;
      end else if (accept) begin
         case (state_q)
            ST_LEN_HI: begin
               len_d   = len_full;
               state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               len_d = len_full;
               if ((len_full == '0) || ({1'b0, len_full} > MAX_LEN)) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               csum_d = csum_q ^ bus.in_data;
               // Address is latched with the word so it lines up with the im_we pulse.
               if (pk_last_byte) begin
                  im_addr_d  = BASE_ADDR + {{(30-LEN_W){1'b0}}, word_idx_q, 2'b00};
                  word_idx_d = word_idx_q + LEN_W'(1);
                  if (word_idx_q == len_q - LEN_W'(1)) begin
                     state_d = ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               state_d = (bus.in_data == csum_q) ? ST_RUN : ST_ERR;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         word_idx_q <= '0;
         csum_q     <= '0;
         im_addr_q  <= BASE_ADDR;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         csum_q     <= csum_d;
         im_addr_q  <= im_addr_d;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.im_we    = pk_word_valid;
   assign bus.im_addr  = im_addr_q;
   assign bus.im_wdata = pk_word;
   assign bus.cpu_run  = (state_q == ST_RUN);
   assign bus.busy     = in_ready;
   assign bus.error    = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed vectors, a table of frames,
// corner sequences and randomized frames against a frame-level model.
module tb_imem_loader;

   localparam logic [31:0] BASE  = 32'h0040_0000;
   localparam int          DEPTH = 256;

   typedef struct {
      logic [15:0] len;
      bit          flip;
      bit          toggle;
      int          start_at;
      bit          exp_run;
      bit          exp_err;
      int          exp_nw;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if bus();

   imem_loader #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [7:0]  frame_bytes[$];
   logic [31:0] exp_words[$];
   vec_t        tbl[9];

   always @(negedge clk) begin
      if (!rst && bus.im_we === 1'b1) begin
         wr_addr_q.push_back(bus.im_addr);
         wr_data_q.push_back(bus.im_wdata);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, ".in_ready"}, 32'(bus.in_ready), 32'd0);
      check({name, ".im_we"},    32'(bus.im_we),    32'd0);
      check({name, ".im_addr"},  bus.im_addr,       BASE);
      check({name, ".im_wdata"}, bus.im_wdata,      32'd0);
      check({name, ".cpu_run"},  32'(bus.cpu_run),  32'd0);
      check({name, ".busy"},     32'(bus.busy),     32'd0);
      check({name, ".error"},    32'(bus.error),    32'd0);
   endtask

   // Frame = length, each word MSB first, then XOR of all data bytes.
   task automatic build_bytes(input logic [15:0] len, input bit flip);
      logic [7:0] x;
      x = 8'h00;
      frame_bytes.delete();
      frame_bytes.push_back(len[15:8]);
      frame_bytes.push_back(len[7:0]);
      if (exp_words.size() == 0) return;
      foreach (exp_words[i]) begin
         for (int b = 3; b >= 0; b--) begin
            frame_bytes.push_back(exp_words[i][8*b +: 8]);
            x = x ^ exp_words[i][8*b +: 8];
         end
      end
      frame_bytes.push_back(flip ? ~x : x);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.load_start = 1'b1;
      @(negedge clk);
      bus.load_start = 1'b0;
   endtask

   task automatic send_bytes(input bit toggle, input int start_at, input int count);
      int idx = 0;
      int cyc = 0;
      bit phase = 1'b0;
      bit pulsed = 1'b0;
      while (idx < count && cyc < 4 * count + 50) begin
         bus.load_start = 1'b0;
         if (idx == start_at && !pulsed) begin
            bus.load_start = 1'b1;
            pulsed = 1'b1;
         end
         if (toggle && phase) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = frame_bytes[idx];
            if (bus.in_ready) idx++;
         end
         phase = !phase;
         cyc++;
         @(negedge clk);
      end
      bus.in_valid   = 1'b0;
      bus.load_start = 1'b0;
      check("bytes_accepted", idx, count);
   endtask

   task automatic run_frame(input string name, input logic [15:0] len, input bit flip,
                            input bit toggle, input int start_at, input bit prebuilt,
                            input bit exp_run, input bit exp_err, input int exp_nw);
      int last;
      if (!prebuilt) begin
         exp_words.delete();
         if (len != 16'd0 && int'(len) <= DEPTH) begin
            for (int i = 0; i < int'(len); i++) exp_words.push_back($urandom);
         end
         build_bytes(len, flip);
      end
      wr_addr_q.delete();
      wr_data_q.delete();
      pulse_start();
      check({name, ".start_cpu_run"},  32'(bus.cpu_run),  32'd0);
      check({name, ".start_error"},    32'(bus.error),    32'd0);
      check({name, ".start_busy"},     32'(bus.busy),     32'd1);
      check({name, ".start_in_ready"}, 32'(bus.in_ready), 32'd1);
      send_bytes(toggle, start_at, frame_bytes.size());
      repeat (3) @(negedge clk);
      check({name, ".cpu_run"},  32'(bus.cpu_run),  32'(exp_run));
      check({name, ".error"},    32'(bus.error),    32'(exp_err));
      check({name, ".busy"},     32'(bus.busy),     32'd0);
      check({name, ".in_ready"}, 32'(bus.in_ready), 32'd0);
      check({name, ".im_we"},    32'(bus.im_we),    32'd0);
      check({name, ".writes"},   wr_addr_q.size(),  exp_nw);
      for (int i = 0; i < wr_addr_q.size() && i < exp_words.size(); i++) begin
         check($sformatf("%s.addr%0d", name, i), wr_addr_q[i], BASE + 32'(4 * i));
         check($sformatf("%s.data%0d", name, i), wr_data_q[i], exp_words[i]);
      end
      if (exp_nw > 0 && exp_words.size() > 0) begin
         last = exp_words.size() - 1;
         check({name, ".hold_addr"},  bus.im_addr,  BASE + 32'(4 * last));
         check({name, ".hold_wdata"}, bus.im_wdata, exp_words[last]);
      end
      $display("frame %s: len=%0d writes=%0d cpu_run=%0b error=%0b",
               name, len, wr_addr_q.size(), bus.cpu_run, bus.error);
   endtask

   initial begin
      logic [15:0] rlen;
      bit          rflip, rtog, valid;
      int          r;

      tbl[0] = '{16'd1,    1'b0, 1'b0, -1, 1'b1, 1'b0, 1};
      tbl[1] = '{16'h0000, 1'b0, 1'b0, -1, 1'b0, 1'b1, 0};
      tbl[2] = '{16'h0101, 1'b0, 1'b0, -1, 1'b0, 1'b1, 0};
      tbl[3] = '{16'd1,    1'b1, 1'b0, -1, 1'b0, 1'b1, 1};
      tbl[4] = '{16'd3,    1'b0, 1'b1, -1, 1'b1, 1'b0, 3};
      tbl[5] = '{16'd4,    1'b0, 1'b0,  5, 1'b1, 1'b0, 4};
      tbl[6] = '{16'd256,  1'b0, 1'b0, -1, 1'b1, 1'b0, 256};
      tbl[7] = '{16'hFFFF, 1'b0, 1'b0, -1, 1'b0, 1'b1, 0};
      tbl[8] = '{16'd5,    1'b1, 1'b1, -1, 1'b0, 1'b1, 5};

      bus.load_start = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Reference image: two words, checksum 0x2D.
      frame_bytes = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
      exp_words   = '{32'h2008_0005, 32'h0000_0000};
      run_frame("ref_image", 16'd2, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b0, 2);

      // Bytes offered while running must be dropped.
      wr_addr_q.delete();
      wr_data_q.delete();
      repeat (4) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = 8'($urandom);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("run_drop.writes",  wr_addr_q.size(),   0);
      check("run_drop.cpu_run", 32'(bus.cpu_run),   32'd1);
      check("run_drop.busy",    32'(bus.busy),      32'd0);

      for (int i = 0; i < 9; i++) begin
         run_frame($sformatf("vec%0d", i), tbl[i].len, tbl[i].flip, tbl[i].toggle,
                   tbl[i].start_at, 1'b0, tbl[i].exp_run, tbl[i].exp_err, tbl[i].exp_nw);
      end

      // Reset after six data bytes: one word already written, everything else cleared.
      exp_words.delete();
      exp_words.push_back($urandom);
      exp_words.push_back($urandom);
      build_bytes(16'd2, 1'b0);
      wr_addr_q.delete();
      wr_data_q.delete();
      pulse_start();
      send_bytes(1'b0, -1, 8);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      check("midrst.writes", wr_addr_q.size(), 1);
      if (wr_addr_q.size() > 0) begin
         check("midrst.addr0", wr_addr_q[0], BASE);
         check("midrst.data0", wr_data_q[0], exp_words[0]);
      end
      $display("frame midrst: len=2 writes=%0d reset after 6 data bytes", wr_addr_q.size());
      rst = 1'b0;
      run_frame("reload", 16'd2, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 2);

      // Randomized frames; outcome follows from the length and checksum rules alone.
      for (int k = 0; k < 10; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      rlen = 16'd0;
         else if (r == 1) rlen = 16'(DEPTH + 1 + $urandom_range(0, 1000));
         else             rlen = 16'($urandom_range(1, 8));
         rflip = ($urandom_range(0, 3) == 0);
         rtog  = 1'($urandom_range(0, 1));
         valid = (rlen != 16'd0) && (int'(rlen) <= DEPTH);
         run_frame($sformatf("rnd%0d", k), rlen, rflip, rtog, -1, 1'b0,
                   valid && !rflip, !(valid && !rflip), valid ? int'(rlen) : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
